reg_op_sequencer: RTL and testbench
===================================

Name: reg_op_sequencer

Overview:
- Command-driven micro-sequencer directly upstream of the 4-bit `register` and `alu` blocks.
- Accepts one command per valid/ready handshake and expands it into single-cycle register control pulses (cl/ld/inc/dec/sr/sl) plus ALU opcode and operands.
- For ALU commands, writes the ALU result back into the register.
- Reports completion with a one-cycle done pulse carrying the register value.

Parameters:
- DATA_W, 4, datapath width (matches register/alu)
- OC_W, 3, ALU opcode width
- CNT_W, 2, shift repeat-count width (shifts performed = cmd_cnt+1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept command
- cmd_op  input  4  opcode (encoding below)
- cmd_imm  input  DATA_W  immediate: load value / ALU operand b
- cmd_cnt  input  CNT_W  shift count minus one
- cmd_fill  input  1  serial fill bit for shifts
- reg_out  input  DATA_W  register current value
- alu_f  input  DATA_W  ALU combinational result
- reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl  output  1 each  register control pulses
- reg_ir, reg_il  output  1 each  serial fill inputs to register
- reg_in  output  DATA_W  register parallel load data
- alu_oc  output  OC_W  ALU opcode
- alu_a, alu_b  output  DATA_W  ALU operands
- done  output  1  one-cycle completion pulse
- result  output  DATA_W  register value sampled at completion, held until next done

Behaviour:
- Opcodes: 0 NOP, 1 CLR, 2 LDI, 3 INC, 4 DEC, 5 SHR, 6 SHL, 7 reserved (executes as NOP), 8–15 ALU with alu_oc = cmd_op[2:0].
- Command capture: op/imm/cnt/fill are latched internally on the accept edge, where accept = cmd_valid & cmd_ready. Inputs are ignored after accept.
- States:
  - IDLE: cmd_ready=1; all reg_* controls 0. On accept → ISSUE, SHIFT or ALU_RD according to the opcode.
  - ISSUE (NOP/CLR/LDI/INC/DEC): exactly one control high for one cycle. LDI drives reg_ld=1 with reg_in=imm. → DONE.
  - SHIFT: reg_sr (SHR) or reg_sl (SHL) held high for cnt+1 consecutive cycles. reg_ir (SHR) or reg_il (SHL) = fill throughout. A down-counter is loaded with cnt; leave for DONE when it reaches 0.
  - ALU_RD: alu_oc=op[2:0], alu_a=reg_out, alu_b=imm; no register control. → ALU_WB.
  - ALU_WB: operands unchanged; reg_ld=1, reg_in=alu_f. → DONE.
  - DONE: done=1, result<=reg_out (value after the update); controls 0. → IDLE.
- Latency, counted in edges from the accept edge to the done cycle:
  - single-op commands: done visible 2 cycles after accept;
  - SHIFT: cnt+2 cycles;
  - ALU: 3 cycles.
- cmd_ready is 0 outside IDLE. No back-to-back accept; the next accept is possible on the edge ending DONE+1 (IDLE cycle).
- Outside their active states, reg_in, alu_oc, alu_a and alu_b are 0. At most one of cl/ld/inc/dec/sr/sl is high in any cycle.
- Reset: on any edge with rst=1 → IDLE. cmd_ready=1 after reset; all controls, reg_in, alu_*, done, result = 0. The in-flight command is discarded with no done. Register updates already clocked stay; the sequencer never resets the register itself.
- rst and cmd_valid together: reset wins, no accept.
- cmd_valid held across DONE: not accepted until IDLE.

Decomposition:
- Shared package `seq_pkg`:
  - opcode localparams (OP_NOP … OP_SHL, OP_ALU_BIT=3);
  - state encoding (IDLE, ISSUE, SHIFT, ALU_RD, ALU_WB, DONE);
  - DATA_W/OC_W defaults.
- Single module, no sub-module; FSM, shift counter and capture registers are local.

Test Plan (bench instantiates sequencer + register + alu, register rst_n tied high after init):
- rst=1 for 2 cycles mid-SHIFT (cnt=3) → next cycle all controls 0, cmd_ready=1, done never pulses for that command.
- LDI imm=0111, then INC → done pulses twice; result=0111 then 1000; reg_ld high exactly 1 cycle, reg_inc high exactly 1 cycle.
- LDI 1010, then SHR cnt=1 fill=1 → reg_sr high 2 consecutive cycles with reg_ir=1; result=1110; done 3 cycles after accept.
- LDI 0001, then ALU op=1011 imm=0011 → alu_oc=011, alu_a=0001, alu_b=0011 for 2 cycles; reg_ld with reg_in=alu_f in the 2nd; result equals the alu model output.
- cmd_valid held high continuously with 4 commands → accepts only in IDLE cycles, one command per done; cmd_ready never high while busy; opcode 7 yields result unchanged.
- DEC from 0000 → result=1111 (wrap); CLR → result=0000.

Source files
------------

// File: rtl/reg_op_sequencer_pkg.sv
// Shared opcode, state and width definitions for the register/ALU micro-sequencer.
package seq_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_OC_W   = 3;
  localparam int DEF_CNT_W  = 2;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_CLR = 4'd1;
  localparam logic [3:0] OP_LDI = 4'd2;
  localparam logic [3:0] OP_INC = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam int         OP_ALU_BIT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SHIFT,
    S_ALU_RD,
    S_ALU_WB,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/reg_op_sequencer.sv
// Expands one handshaked command into register control pulses / ALU write-back,
// then signals completion with a done pulse carrying the register value.
module reg_op_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OC_W   = DEF_OC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic              cmd_fill,
  input  logic [DATA_W-1:0] reg_out,
  input  logic [DATA_W-1:0] alu_f,
  output logic              reg_cl,
  output logic              reg_ld,
  output logic              reg_inc,
  output logic              reg_dec,
  output logic              reg_sr,
  output logic              reg_sl,
  output logic              reg_ir,
  output logic              reg_il,
  output logic [DATA_W-1:0] reg_in,
  output logic [OC_W-1:0]   alu_oc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  seq_state_t        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] result_q, result_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      imm_q    <= '0;
      cnt_q    <= '0;
      fill_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    imm_d     = imm_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    result_d  = result_q;
    cmd_ready = 1'b0;
    reg_cl    = 1'b0;
    reg_ld    = 1'b0;
    reg_inc   = 1'b0;
    reg_dec   = 1'b0;
    reg_sr    = 1'b0;
    reg_sl    = 1'b0;
    reg_ir    = 1'b0;
    reg_il    = 1'b0;
    reg_in    = '0;
    alu_oc    = '0;
    alu_a     = '0;
    alu_b     = '0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = cmd_op;
          imm_d  = cmd_imm;
          cnt_d  = cmd_cnt;
          fill_d = cmd_fill;
          if (cmd_op[OP_ALU_BIT])                         state_d = S_ALU_RD;
          else if (cmd_op == OP_SHR || cmd_op == OP_SHL)  state_d = S_SHIFT;
          else                                            state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        case (op_q)
          OP_CLR:  reg_cl  = 1'b1;
          OP_LDI: begin
            reg_ld = 1'b1;
            reg_in = imm_q;
          end
          OP_INC:  reg_inc = 1'b1;
          OP_DEC:  reg_dec = 1'b1;
          default: ;
        endcase
        state_d = S_DONE;
      end
      S_SHIFT: begin
        if (op_q == OP_SHR) begin
          reg_sr = 1'b1;
          reg_ir = fill_q;
        end else begin
          reg_sl = 1'b1;
          reg_il = fill_q;
        end
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ALU_RD, S_ALU_WB: begin
        alu_oc = op_q[OC_W-1:0];
        alu_a  = reg_out;
        alu_b  = imm_q;
        if (state_q == S_ALU_WB) begin
          reg_ld  = 1'b1;
          reg_in  = alu_f;
          state_d = S_DONE;
        end else begin
          state_d = S_ALU_WB;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        result_d = reg_out;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The register has already absorbed the update when DONE is entered, so the
  // live value is forwarded during the done cycle and held from then on.
  assign result = (state_q == S_DONE) ? reg_out : result_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Randomized bench: sequencer driving a behavioural 4-bit register and ALU,
// checked command-by-command against an arithmetic reference model.
module tb_reg_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_imm;
  logic [1:0] cmd_cnt;
  logic       cmd_fill;
  logic [3:0] reg_out;
  logic [3:0] alu_f;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il;
  logic [3:0] reg_in;
  logic [2:0] alu_oc;
  logic [3:0] alu_a, alu_b;
  logic       done;
  logic [3:0] result;

  int checks = 0;
  int fails  = 0;

  logic [3:0] r = 4'd0;
  logic [3:0] exp_reg = 4'd0;
  logic [3:0] prev_result = 4'd0;

  always #5 clk = ~clk;

  reg_op_sequencer #(.DATA_W(4), .OC_W(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
    .reg_out(reg_out), .alu_f(alu_f),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_ir(reg_ir), .reg_il(reg_il),
    .reg_in(reg_in), .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b),
    .done(done), .result(result)
  );

  function automatic logic [3:0] alu_fn(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
    case (oc)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return b;
      default: return a + 4'd1;
    endcase
  endfunction

  // Environment: 4-bit register and combinational ALU.
  always @(posedge clk) begin
    if (reg_cl)       r <= 4'd0;
    else if (reg_ld)  r <= reg_in;
    else if (reg_inc) r <= r + 4'd1;
    else if (reg_dec) r <= r - 4'd1;
    else if (reg_sr)  r <= {reg_ir, r[3:1]};
    else if (reg_sl)  r <= {r[2:0], reg_il};
  end
  assign reg_out = r;
  assign alu_f   = alu_fn(alu_oc, alu_a, alu_b);

  function automatic logic [3:0] ref_apply(input logic [3:0] op, input logic [3:0] imm,
                                           input logic [1:0] cnt, input logic fill,
                                           input logic [3:0] cur);
    logic [3:0] v;
    v = cur;
    if (op >= 4'd8) v = alu_fn(op[2:0], cur, imm);
    else case (op)
      4'd1: v = 4'd0;
      4'd2: v = imm;
      4'd3: v = cur + 4'd1;
      4'd4: v = cur - 4'd1;
      4'd5: for (int k = 0; k <= int'(cnt); k++) v = (v >> 1) | (4'(fill) << 3);
      4'd6: for (int k = 0; k <= int'(cnt); k++) v = (v << 1) | 4'(fill);
      default: v = cur;
    endcase
    return v;
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge. Presents the command, waits for acceptance, then
  // follows it to done and compares against the reference model.
  task automatic run_cmd(input logic [3:0] op, input logic [3:0] imm, input logic [1:0] cnt,
                         input logic fill, input bit hold, input int exp_wait);
    int w, lat;
    int n_cl, n_ld, n_inc, n_dec, n_sr, n_sl, n_multi, n_fill_err, n_alu_err, n_ready_err, n_ldval_err;
    bit is_alu, is_shr, is_shl;
    int exp_lat;
    logic [3:0] exp_new, exp_ld_val;

    cmd_op = op; cmd_imm = imm; cmd_cnt = cnt; cmd_fill = fill; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("accept_wait", w, exp_wait);
    check_eq("idle_result_hold", int'(result), int'(prev_result));
    check_eq("idle_done_low", int'(done), 0);

    is_alu = op[3];
    is_shr = (op == 4'd5);
    is_shl = (op == 4'd6);
    exp_lat = is_alu ? 3 : ((is_shr || is_shl) ? int'(cnt) + 2 : 2);
    exp_new = ref_apply(op, imm, cnt, fill, exp_reg);
    exp_ld_val = is_alu ? alu_fn(op[2:0], exp_reg, imm) : imm;

    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;

    {n_cl, n_ld, n_inc, n_dec, n_sr, n_sl} = '0;
    {n_multi, n_fill_err, n_alu_err, n_ready_err, n_ldval_err} = '0;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      n_cl  += int'(reg_cl);  n_ld += int'(reg_ld); n_inc += int'(reg_inc);
      n_dec += int'(reg_dec); n_sr += int'(reg_sr); n_sl  += int'(reg_sl);
      if (int'(reg_cl) + int'(reg_ld) + int'(reg_inc) + int'(reg_dec) + int'(reg_sr) + int'(reg_sl) > 1)
        n_multi++;
      if (reg_ir !== (reg_sr & fill) || reg_il !== (reg_sl & fill)) n_fill_err++;
      if (cmd_ready) n_ready_err++;
      if (reg_ld && reg_in !== exp_ld_val) n_ldval_err++;
      if (!reg_ld && reg_in !== 4'd0) n_ldval_err++;
      if (is_alu && n <= 2) begin
        if (alu_oc !== op[2:0] || alu_a !== exp_reg || alu_b !== imm) n_alu_err++;
      end else if (alu_oc !== 3'd0 || alu_a !== 4'd0 || alu_b !== 4'd0) begin
        n_alu_err++;
      end
      if (done) begin
        lat = n;
        break;
      end
    end

    check_eq("latency", lat, exp_lat);
    check_eq("result", int'(result), int'(exp_new));
    check_eq("n_cl", n_cl, int'(op == 4'd1));
    check_eq("n_ld", n_ld, int'(op == 4'd2 || is_alu));
    check_eq("n_inc", n_inc, int'(op == 4'd3));
    check_eq("n_dec", n_dec, int'(op == 4'd4));
    check_eq("n_sr", n_sr, is_shr ? int'(cnt) + 1 : 0);
    check_eq("n_sl", n_sl, is_shl ? int'(cnt) + 1 : 0);
    check_eq("onehot_ctrl", n_multi, 0);
    check_eq("fill_bits", n_fill_err, 0);
    check_eq("alu_operands", n_alu_err, 0);
    check_eq("ready_busy", n_ready_err, 0);
    check_eq("reg_in_val", n_ldval_err, 0);
    exp_reg = exp_new;
    prev_result = exp_new;
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_imm = '0; cmd_cnt = '0; cmd_fill = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", int'(cmd_ready), 1);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_result", int'(result), 0);
    check_eq("rst_ctrls", int'({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il}), 0);
    check_eq("rst_outs", int'({reg_in, alu_oc, alu_a, alu_b}), 0);

    // LDI then INC
    run_cmd(4'd2, 4'b0111, 2'd0, 1'b0, 1'b0, 0);
    run_cmd(4'd3, 4'd0,    2'd0, 1'b0, 1'b0, 1);
    // LDI then SHR cnt=1 fill=1 -> 1110
    run_cmd(4'd2, 4'b1010, 2'd0, 1'b0, 1'b0, 1);
    run_cmd(4'd5, 4'd0,    2'd1, 1'b1, 1'b0, 1);
    // LDI then ALU OR
    run_cmd(4'd2, 4'b0001, 2'd0, 1'b0, 1'b0, 1);
    run_cmd(4'b1011, 4'b0011, 2'd0, 1'b0, 1'b0, 1);
    // CLR, DEC wrap, CLR
    run_cmd(4'd1, 4'd0, 2'd0, 1'b0, 1'b0, 1);
    run_cmd(4'd4, 4'd0, 2'd0, 1'b0, 1'b0, 1);
    run_cmd(4'd1, 4'd0, 2'd0, 1'b0, 1'b0, 1);
    // cmd_valid held continuously across four commands
    run_cmd(4'd2, 4'b0101, 2'd0, 1'b0, 1'b1, 1);
    run_cmd(4'd3, 4'd0,    2'd0, 1'b0, 1'b1, 1);
    run_cmd(4'd7, 4'b1111, 2'd3, 1'b1, 1'b1, 1);
    run_cmd(4'd6, 4'd0,    2'd2, 1'b0, 1'b1, 1);
    cmd_valid = 1'b0;

    // Reset in the middle of a 4-cycle SHR: two shifts land, no done.
    run_cmd(4'd2, 4'b1010, 2'd0, 1'b0, 1'b0, 1);
    @(negedge clk);
    cmd_op = 4'd5; cmd_cnt = 2'd3; cmd_fill = 1'b1; cmd_imm = '0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      seen_done += int'(done);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      seen_done += int'(done);
    end
    rst = 1'b0;
    check_eq("midrst_ready", int'(cmd_ready), 1);
    check_eq("midrst_ctrls", int'({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il}), 0);
    check_eq("midrst_result", int'(result), 0);
    repeat (4) begin
      @(negedge clk);
      seen_done += int'(done);
    end
    check_eq("midrst_no_done", seen_done, 0);
    exp_reg = 4'b1110;
    prev_result = 4'd0;
    run_cmd(4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 0);

    // Randomized commands, random hold of cmd_valid.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] rop, rimm;
      logic [1:0] rcnt;
      rop  = 4'($urandom_range(0, 15));
      rimm = 4'($urandom);
      rcnt = 2'($urandom);
      run_cmd(rop, rimm, rcnt, 1'($urandom), 1'($urandom_range(0, 1)), 1);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
